// File: rtl/sram_pm_pkg.sv
// Shared types for the SRAM bank power-managed wrapper.
package sram_pm_pkg;

    typedef enum logic [1:0] {
        ACTIVE    = 2'b00,
        DRAIN     = 2'b01,
        RETENTIVE = 2'b10,
        WAKEUP    = 2'b11
    } pwr_state_e;

    localparam int unsigned MaxReadLatency = 2;

endpackage

// File: rtl/sram_array_beh.sv
// Behavioural byte-enabled single-port array with 1-cycle synchronous read.
// Swap point for a technology macro; out-of-range accesses are ignored and read as 0.
module sram_array_beh #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] r_mem [NumWords];
    logic [DataWidth-1:0] r_rdata;
    logic                 w_in_range;

    always_comb begin
        w_in_range = (32'(addr_i) < NumWords);
    end

    always_ff @(posedge clk_i) begin
        if (req_i && we_i && w_in_range) begin
            for (int unsigned k = 0; k < BeWidth; k++) begin
                if (be_i[k]) begin
                    r_mem[addr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_i && !we_i) begin
            r_rdata <= w_in_range ? r_mem[addr_i] : '0;
        end
    end

    always_comb begin
        rdata_o = r_rdata;
    end

endmodule

// File: rtl/sram_bank_pm_wrapper.sv
// Single-port SRAM bank with OBI-style grant/rvalid, 1- or 2-cycle read latency
// and a retention power-mode FSM (drain, retain, timed wake-up).
module sram_bank_pm_wrapper
    import sram_pm_pkg::*;
#(
    parameter int unsigned NumWords     = 1024,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned ReadLatency  = 1,
    parameter int unsigned WakeupCycles = 4,
    parameter int unsigned AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth      = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    input  logic                 set_retentive_ni,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic [1:0]           pwr_state_o
);

    localparam int unsigned CntWidth = (WakeupCycles > 0) ? $clog2(WakeupCycles + 1) : 1;
    localparam logic [CntWidth-1:0] WakeLoad = CntWidth'(WakeupCycles);

    if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : g_bad_latency
        $error("sram_bank_pm_wrapper: ReadLatency must be 1 or 2");
    end
    if (DataWidth % 8 != 0) begin : g_bad_width
        $error("sram_bank_pm_wrapper: DataWidth must be a multiple of 8");
    end

    pwr_state_e           r_state, w_state_next;
    logic [CntWidth-1:0]  r_wake_cnt, w_wake_cnt_next;
    logic                 w_gnt;
    logic                 r_v1, r_rd1;
    logic                 w_resp_valid, w_resp_read, w_inflight;
    logic [DataWidth-1:0] w_array_rdata, w_resp_data, r_rdata_hold;

    always_comb begin
        w_gnt = req_i & (r_state == ACTIVE) & set_retentive_ni;
    end

    sram_array_beh #(
        .NumWords  (NumWords),
        .DataWidth (DataWidth)
    ) u_array (
        .clk_i   (clk_i),
        .req_i   (w_gnt),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .rdata_o (w_array_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v1  <= 1'b0;
            r_rd1 <= 1'b0;
        end else begin
            r_v1  <= w_gnt;
            r_rd1 <= w_gnt & ~we_i;
        end
    end

    if (ReadLatency == 2) begin : g_lat2
        logic                 r_v2, r_rd2;
        logic [DataWidth-1:0] r_rdata2;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_v2     <= 1'b0;
                r_rd2    <= 1'b0;
                r_rdata2 <= '0;
            end else begin
                r_v2  <= r_v1;
                r_rd2 <= r_rd1;
                if (r_rd1) begin
                    r_rdata2 <= w_array_rdata;
                end
            end
        end

        always_comb begin
            w_resp_valid = r_v2;
            w_resp_read  = r_rd2;
            w_resp_data  = r_rdata2;
            w_inflight   = r_v1 | r_v2;
        end
    end else begin : g_lat1
        always_comb begin
            w_resp_valid = r_v1;
            w_resp_read  = r_rd1;
            w_resp_data  = w_array_rdata;
            w_inflight   = r_v1;
        end
    end

    // Read data is shown only on read responses; otherwise the last read value is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata_hold <= '0;
        end else if (w_resp_valid && w_resp_read) begin
            r_rdata_hold <= w_resp_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ACTIVE;
            r_wake_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wake_cnt <= w_wake_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wake_cnt_next = r_wake_cnt;
        case (r_state)
            ACTIVE: begin
                if (!set_retentive_ni) w_state_next = DRAIN;
            end
            DRAIN: begin
                if (!w_inflight) begin
                    w_state_next = RETENTIVE;
                end else if (set_retentive_ni) begin
                    w_state_next    = WAKEUP;
                    w_wake_cnt_next = WakeLoad;
                end
            end
            RETENTIVE: begin
                if (set_retentive_ni) begin
                    w_state_next    = WAKEUP;
                    w_wake_cnt_next = WakeLoad;
                end
            end
            WAKEUP: begin
                // Leave once the counter would reach 0, so WAKEUP lasts max(WakeupCycles,1) cycles.
                if (!set_retentive_ni) begin
                    w_state_next    = RETENTIVE;
                    w_wake_cnt_next = '0;
                end else if (r_wake_cnt <= CntWidth'(1)) begin
                    w_state_next    = ACTIVE;
                    w_wake_cnt_next = '0;
                end else begin
                    w_wake_cnt_next = r_wake_cnt - CntWidth'(1);
                end
            end
            default: w_state_next = ACTIVE;
        endcase
    end

    always_comb begin
        gnt_o       = w_gnt;
        rvalid_o    = w_resp_valid;
        rdata_o     = (w_resp_valid && w_resp_read) ? w_resp_data : r_rdata_hold;
        pwr_state_o = r_state;
    end

endmodule

// File: tb/tb_sram_bank_pm_wrapper.sv
// Bench for sram_bank_pm_wrapper: latency-1 and latency-2 instances share stimulus
// and are compared against an array/history reference model.
module tb_sram_bank_pm_wrapper;

    localparam int unsigned NW = 1000;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned BW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic          ret_n = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [BW-1:0] be = '0;

    logic          gnt [2];
    logic          rv [2];
    logic [DW-1:0] rdat [2];
    logic [1:0]    ps [2];

    always #5 clk = ~clk;

    sram_bank_pm_wrapper #(
        .NumWords(NW), .DataWidth(DW), .ReadLatency(1), .WakeupCycles(4)
    ) u_dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt[0]), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .set_retentive_ni(ret_n),
        .rvalid_o(rv[0]), .rdata_o(rdat[0]), .pwr_state_o(ps[0])
    );

    sram_bank_pm_wrapper #(
        .NumWords(NW), .DataWidth(DW), .ReadLatency(2), .WakeupCycles(4)
    ) u_dut_l2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt[1]), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .set_retentive_ni(ret_n),
        .rvalid_o(rv[1]), .rdata_o(rdat[1]), .pwr_state_o(ps[1])
    );

    // Reference: per-instance memory image and grant history ([1] = last cycle, [2] = two ago).
    logic [DW-1:0] mem [2][NW];
    bit            pv  [2][3];
    bit            prd [2][3];
    logic [DW-1:0] pd  [2][3];
    logic [DW-1:0] hold [2];
    int            errors = 0;
    int            checks = 0;

    // Starts and ends at a negedge; es0/es1 are the expected power states this cycle.
    task automatic tick(input int es0, input int es1);
        int            es [2];
        bit            g [2];
        bit            ev;
        int            lat;
        logic [DW-1:0] er;
        es[0] = es0;
        es[1] = es1;
        #1;
        for (int d = 0; d < 2; d++) begin
            lat  = d + 1;
            g[d] = req && ret_n && (es[d] == 0);
            checks++;
            if (gnt[d] !== g[d]) begin
                errors++;
                $display("FAIL gnt dut%0d t=%0t got=%b exp=%b", d, $time, gnt[d], g[d]);
            end
            checks++;
            if (ps[d] !== 2'(es[d])) begin
                errors++;
                $display("FAIL pwr_state dut%0d t=%0t got=%b exp=%b", d, $time, ps[d], 2'(es[d]));
            end
            ev = pv[d][lat];
            er = (ev && prd[d][lat]) ? pd[d][lat] : hold[d];
            checks++;
            if (rv[d] !== ev) begin
                errors++;
                $display("FAIL rvalid dut%0d t=%0t got=%b exp=%b", d, $time, rv[d], ev);
            end
            checks++;
            if (rdat[d] !== er) begin
                errors++;
                $display("FAIL rdata dut%0d t=%0t got=%h exp=%h", d, $time, rdat[d], er);
            end
            hold[d] = er;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            pv[d][2]  = pv[d][1];
            prd[d][2] = prd[d][1];
            pd[d][2]  = pd[d][1];
            pv[d][1]  = g[d];
            prd[d][1] = g[d] && !we;
            pd[d][1]  = (addr < NW) ? mem[d][addr] : '0;
            if (g[d] && we && addr < NW) begin
                for (int k = 0; k < int'(BW); k++) begin
                    if (be[k]) mem[d][addr][k*8 +: 8] = wdata[k*8 +: 8];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        req   = 1'b0;
        we    = 1'b0;
        ret_n = 1'b1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rv[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_rvalid dut%0d got=%b exp=0", d, rv[d]);
            end
            checks++;
            if (rdat[d] !== '0) begin
                errors++;
                $display("FAIL reset_rdata dut%0d got=%h exp=0", d, rdat[d]);
            end
            checks++;
            if (ps[d] !== 2'b00) begin
                errors++;
                $display("FAIL reset_state dut%0d got=%b exp=00", d, ps[d]);
            end
            checks++;
            if (gnt[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_gnt dut%0d got=%b exp=0", d, gnt[d]);
            end
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            hold[d] = '0;
            for (int i = 0; i < 3; i++) begin
                pv[d][i]  = 1'b0;
                prd[d][i] = 1'b0;
            end
        end
    endtask

    task automatic op(input bit r, input bit w, input int a, input logic [DW-1:0] dat,
                      input logic [BW-1:0] b);
        req   = r;
        we    = w;
        addr  = AW'(a);
        wdata = dat;
        be    = b;
    endtask

    task automatic test_reset();
        #2;
        do_reset();
        tick(0, 0);
    endtask

    task automatic test_basic();
        op(1, 1, 5, 32'hDEADBEEF, 4'hF); tick(0, 0);
        op(1, 0, 5, '0, '0);             tick(0, 0);
        op(0, 0, 0, '0, '0);             tick(0, 0); tick(0, 0);
        op(1, 1, 5, 32'h11223344, 4'b0101); tick(0, 0);
        op(1, 0, 5, '0, '0);             tick(0, 0);
        op(0, 0, 0, '0, '0);             tick(0, 0); tick(0, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdat[d] !== 32'hDE22BE44) begin
                errors++;
                $display("FAIL partial_write dut%0d got=%h exp=de22be44", d, rdat[d]);
            end
        end
        op(1, 1, 5, 32'hFFFFFFFF, 4'h0); tick(0, 0);
        op(1, 1, 1003, 32'hCAFEF00D, 4'hF); tick(0, 0);
        op(1, 0, 5, '0, '0);             tick(0, 0);
        op(0, 0, 0, '0, '0);             tick(0, 0); tick(0, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdat[d] !== 32'hDE22BE44) begin
                errors++;
                $display("FAIL be_zero dut%0d got=%h exp=de22be44", d, rdat[d]);
            end
        end
        op(1, 0, 1003, '0, '0);          tick(0, 0);
        op(0, 0, 0, '0, '0);             tick(0, 0); tick(0, 0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdat[d] !== '0) begin
                errors++;
                $display("FAIL out_of_range dut%0d got=%h exp=0", d, rdat[d]);
            end
        end
    endtask

    task automatic test_random_traffic();
        int a;
        for (int i = 0; i < 16; i++) begin
            op(1, 1, i, $urandom, 4'hF); tick(0, 0);
        end
        for (int i = 0; i < 300; i++) begin
            a = int'($urandom_range(19, 0));
            op(($urandom % 4) != 0, $urandom_range(1, 0) == 1, (a < 16) ? a : 1000 + a - 16,
               $urandom, BW'($urandom));
            tick(0, 0);
        end
        op(0, 0, 0, '0, '0); tick(0, 0); tick(0, 0); tick(0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            op(1, 0, i, '0, '0); tick(0, 0);
        end
        op(0, 0, 0, '0, '0); tick(0, 0); tick(0, 0); tick(0, 0);
    endtask

    task automatic test_retention();
        ret_n = 1'b1;
        op(1, 0, 3, '0, '0); tick(0, 0);
        op(0, 0, 0, '0, '0); ret_n = 1'b0; tick(0, 0);
        tick(1, 1);
        tick(2, 1);
        op(1, 0, 5, '0, '0);
        for (int i = 0; i < 4; i++) tick(2, 2);
        ret_n = 1'b1; tick(2, 2);
        for (int i = 0; i < 4; i++) tick(3, 3);
        tick(0, 0);
        for (int i = 0; i < 6; i++) begin
            op(1, 0, i, '0, '0); tick(0, 0);
        end
        op(0, 0, 0, '0, '0); tick(0, 0); tick(0, 0); tick(0, 0);
    endtask

    task automatic test_drain_abort();
        op(1, 0, 1, '0, '0); ret_n = 1'b1; tick(0, 0);
        op(0, 0, 0, '0, '0); ret_n = 1'b0; tick(0, 0);
        ret_n = 1'b1; tick(1, 1);
        tick(2, 3);
        tick(3, 3); tick(3, 3); tick(3, 3);
        op(1, 0, 2, '0, '0); tick(3, 0);
        tick(0, 0);
        op(0, 0, 0, '0, '0); tick(0, 0); tick(0, 0); tick(0, 0);
    endtask

    task automatic test_wakeup_abort_and_reset();
        ret_n = 1'b0; tick(0, 0);
        tick(1, 1);
        ret_n = 1'b1; tick(2, 2);
        tick(3, 3);
        ret_n = 1'b0; tick(3, 3);
        tick(2, 2);
        ret_n = 1'b1; tick(2, 2);
        tick(3, 3); tick(3, 3);
        do_reset();
        tick(0, 0);
        op(1, 0, 2, '0, '0); tick(0, 0);
        op(0, 0, 0, '0, '0);
        do_reset();
        tick(0, 0); tick(0, 0); tick(0, 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            hold[d] = '0;
            for (int i = 0; i < 3; i++) begin
                pv[d][i]  = 1'b0;
                prd[d][i] = 1'b0;
                pd[d][i]  = '0;
            end
        end
        test_reset();
        test_basic();
        test_random_traffic();
        test_back_to_back();
        test_retention();
        test_drain_abort();
        test_wakeup_abort_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_bank_pm_wrapper.md
Name: sram_bank_pm_wrapper

Overview:
- Parametrised single-port SRAM bank wrapper for the core_v_mini_mcu memory subsystem. Generic in data width and depth, with per-byte write enables.
- Adds an OBI-style grant/rvalid handshake and a configurable read latency (1 or 2 cycles).
- Adds a retention power-mode FSM that drains in-flight reads before retention and enforces a wake-up delay before accepting traffic again.
- One instance per bank; the bank's set_retentive_ni bit comes from the power manager.

Parameters:
- NumWords, 1024, number of words in the array.
- DataWidth, 32, word width in bits; must be a multiple of 8.
- ReadLatency, 1, cycles from grant to rvalid_o; legal values 1 or 2; elaboration error otherwise.
- WakeupCycles, 4, cycles spent in WAKEUP after retention exit; 0 is legal.
- AddrWidth, (NumWords>1)?$clog2(NumWords):1, derived; do not override.
- BeWidth, DataWidth/8, derived; do not override.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  1  request; master holds it and its fields stable until gnt_o.
- gnt_o  output  1  request accepted this cycle.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  AddrWidth  word address.
- wdata_i  input  DataWidth  write data.
- be_i  input  BeWidth  byte enables (write only).
- set_retentive_ni  input  1  0 = request retention.
- rvalid_o  output  1  response valid, once per granted transaction.
- rdata_o  output  DataWidth  read data.
- pwr_state_o  output  2  current FSM state encoding.

Behaviour:
- Reset (async assert, sync release): state ACTIVE, gnt_o=0, rvalid_o=0, rdata_o=0, wake counter 0, all pipeline valids 0. Array contents are not reset.
- gnt_o = req_i & (state==ACTIVE) & set_retentive_ni. Combinational, zero-wait in ACTIVE.
- Granted write: bytes with be_i[k]=1 are written at the clock edge. Bytes with be_i[k]=0 keep their value. be_i=0 writes nothing.
- Granted read: array read issued at the grant edge.
- Response latency: rvalid_o pulses exactly ReadLatency cycles after the grant cycle, for reads and writes alike.
  - ReadLatency=1: rdata_o is the array output.
  - ReadLatency=2: an extra output register is inserted.
- rdata_o for a write response, and whenever rvalid_o=0, holds its previous value.
- Back-to-back grants every cycle are supported; responses come in order with no bubbles.
- FSM states, with pwr_state_o encoding:
  - ACTIVE (00): normal operation.
  - DRAIN (01): no new grants.
  - RETENTIVE (10): no array access; contents preserved; rdata_o held.
  - WAKEUP (11): counter runs.
- Transitions:
  - ACTIVE -> DRAIN when set_retentive_ni=0.
  - DRAIN -> RETENTIVE when no response is in flight, checked every cycle. DRAIN does not wait if the pipeline is already empty; it lasts exactly 1 cycle minimum.
  - DRAIN -> WAKEUP if set_retentive_ni returns to 1 before the pipeline empties; wake-up is still paid.
  - RETENTIVE -> WAKEUP when set_retentive_ni=1. The counter loads WakeupCycles.
  - WAKEUP -> ACTIVE when the counter reaches 0; it decrements once per cycle in WAKEUP. With WakeupCycles=0, WAKEUP lasts 1 cycle.
  - WAKEUP: set_retentive_ni=0 returns to RETENTIVE immediately, and the counter is discarded.
- Simultaneous req_i and set_retentive_ni falling in the same cycle: not granted; retention wins.
- Reset mid-operation (any state): returns to ACTIVE. In-flight responses are dropped with no rvalid_o.
- Write to an address >= NumWords (non-power-of-2 depth): ignored. Read returns 0.

Decomposition:
- Package sram_pm_pkg holds:
  - typedef enum logic [1:0] pwr_state_e {ACTIVE, DRAIN, RETENTIVE, WAKEUP}.
  - localparam MaxReadLatency = 2.
- One sub-module, sram_array_beh: behavioural byte-enabled single-port array with parameters NumWords and DataWidth and a 1-cycle synchronous read. It is the swap point for a technology macro.
- The FSM, grant logic and response pipeline stay in the top module.

Test Plan:
- Default params: write 0xDEADBEEF to addr 5, be=0xF, then read addr 5 -> rvalid_o 1 cycle after the read grant, rdata_o=0xDEADBEEF.
- Partial write: be=0b0101, wdata 0x11223344 over 0xDEADBEEF at addr 5 -> read returns 0xDE22BE44.
- ReadLatency=2: 4 back-to-back reads of addrs 0..3 -> 4 consecutive rvalid_o pulses starting 2 cycles after the first grant, data in order.
- Read granted, then set_retentive_ni=0 the next cycle -> DRAIN until rvalid_o, then RETENTIVE (pwr_state_o=10). req_i held in RETENTIVE -> gnt_o stays 0.
- Retention exit with WakeupCycles=4 -> WAKEUP, gnt_o=0 during wake-up, ACTIVE and grant resume at the expected cycle; contents written before retention read back unchanged.
- Assert rst_ni low during WAKEUP with a pending response -> outputs go to 0 asynchronously, pwr_state_o=00 after release, no spurious rvalid_o.
